nor_stim_checker: RTL and testbench

- Self-checking stimulus stage for the 2-input NOR gate block.
- Upstream side: sweeps a/b through all four input combinations.
- Downstream side: consumes the gate output c and compares it against ~(a|b) after a programmable settle time.
- Reports mismatch pulses, a saturating error count, and a pass/done result, giving the gate labs a clocked, reusable checker.

---
 rtl/nor_chk_pkg.sv | 19 +
 rtl/nor_settle_timer.sv | 30 +++
 rtl/nor_stim_checker.sv | 160 ++++++++++++++++
 tb/tb_nor_stim_checker.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_chk_pkg.sv
// Shared definitions for the NOR gate stimulus/checker block.
// Holds the FSM encoding, the vector count and the reference model of the gate.
// No logic of its own; imported by the checker top.
package nor_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VECS = 4;

  // Reference behaviour of the gate under check.
  function automatic logic nor_expect(input logic a, input logic b);
    return ~(a | b);
  endfunction

endpackage

// File: rtl/nor_settle_timer.sv
// Settle-time down-counter: load a value, count down to zero, flag zero.
// Latency: o_zero reflects the registered count (valid the cycle after a load).
// Backpressure: none; load takes priority over decrement, count stops at zero.
module nor_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Count register: load overrides, otherwise decrement while non-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/nor_stim_checker.sv
// Drives a/b through 00,01,10,11 and checks the NOR output c after SETTLE_CYCLES edges.
// Latency: start-accept to done = 4*PASSES*SETTLE_CYCLES edges, then one DONE cycle.
// Backpressure: none; start is only sampled in IDLE, ignored in RUN/DONE.
module nor_stim_checker
  import nor_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             c,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
);

  localparam int                CNT_W       = $clog2(SETTLE_CYCLES) + 1;
  localparam int                PASS_W      = $clog2(PASSES) + 1;
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(PASSES - 1);
  localparam logic [1:0]        LAST_VEC    = 2'(NUM_VECS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_vec_idx;
  logic [PASS_W-1:0]  r_pass_cnt;
  logic [ERR_W-1:0]   r_err;
  logic               r_pass;
  logic               r_mismatch;

  logic               w_accept;
  logic               w_sample;
  logic               w_timer_load;
  logic               w_settle_zero;
  logic               w_last_vec;
  logic               w_last_pass;
  logic               w_miss;
  logic [ERR_W-1:0]   w_err_nxt;

  nor_settle_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_timer_load),
    .i_load_val (SETTLE_LOAD),
    .i_dec      (r_state == RUN),
    .o_zero     (w_settle_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, accept/sample strobes and timer reloads.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_timer_load = 1'b0;
    w_last_vec   = (r_vec_idx == LAST_VEC);
    w_last_pass  = (r_pass_cnt == LAST_PASS);
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt  = RUN;
          w_accept     = 1'b1;
          w_timer_load = 1'b1;
        end
      end
      RUN: begin
        if (w_settle_zero) begin
          w_sample = 1'b1;
          if (w_last_vec && w_last_pass) begin
            w_state_nxt = DONE;
          end else begin
            w_timer_load = 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Compare c with the model; an X/Z on c falls to the else branch and counts as a miss.
  always_comb begin
    w_miss    = 1'b0;
    w_err_nxt = r_err;
    if (c == nor_expect(r_vec_idx[1], r_vec_idx[0])) begin
      w_miss = 1'b0;
    end else begin
      w_miss = 1'b1;
    end
    if (w_sample && w_miss && (r_err != ERR_MAX)) begin
      w_err_nxt = r_err + 1'b1;
    end
  end

  // Vector index, pass counter, error count and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec_idx  <= '0;
      r_pass_cnt <= '0;
      r_err      <= '0;
      r_pass     <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= w_sample & w_miss;
      if (w_accept) begin
        r_vec_idx  <= '0;
        r_pass_cnt <= '0;
        r_err      <= '0;
        r_pass     <= 1'b0;
      end else if (w_sample) begin
        r_err <= w_err_nxt;
        if (!w_last_vec) begin
          r_vec_idx <= r_vec_idx + 2'd1;
        end else begin
          // Wrap to vector 00 both for another pass and on the way to DONE.
          r_vec_idx <= '0;
          if (!w_last_pass) begin
            r_pass_cnt <= r_pass_cnt + 1'b1;
          end else begin
            r_pass <= (w_err_nxt == '0);
          end
        end
      end
    end
  end

  // a/b come straight from the vector index flops.
  assign a         = r_vec_idx[1];
  assign b         = r_vec_idx[0];
  assign vec_idx   = r_vec_idx;
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign pass      = r_pass;
  assign mismatch  = r_mismatch;
  assign err_count = r_err;

endmodule

// File: tb/tb_nor_stim_checker.sv
// Scoreboard bench: stimulus pushes expected run results, a negedge monitor pops on done.
// Three checker instances: (S=2,P=1,E=4), (S=2,P=2,E=2), (S=1,P=1,E=4).
module tb_nor_stim_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic c0, c1, c2;
  logic a0, b0, busy0, done0, pass0, mis0;
  logic a1, b1, busy1, done1, pass1, mis1;
  logic a2, b2, busy2, done2, pass2, mis2;
  logic [3:0] err0, err2;
  logic [1:0] err1;
  logic [1:0] vidx0, vidx1, vidx2;

  // Gate models: inst0 correct or stuck-at-0, inst1 stuck-at-1, inst2 one-cycle delayed.
  int   mode0   = 0;
  logic dly_clr = 1'b1;
  logic c2_q    = 1'b0;
  assign c0 = (mode0 == 0) ? ~(a0 | b0) : 1'b0;
  assign c1 = 1'b1;
  always @(posedge clk) begin
    if (dly_clr) c2_q <= 1'b0;
    else         c2_q <= ~(a2 | b2);
  end
  assign c2 = c2_q;

  nor_stim_checker #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(4)) u_dut0 (
    .clk(clk), .rst(rst0), .start(start0), .c(c0), .a(a0), .b(b0), .busy(busy0),
    .done(done0), .pass(pass0), .mismatch(mis0), .err_count(err0), .vec_idx(vidx0));
  nor_stim_checker #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .c(c1), .a(a1), .b(b1), .busy(busy1),
    .done(done1), .pass(pass1), .mismatch(mis1), .err_count(err1), .vec_idx(vidx1));
  nor_stim_checker #(.SETTLE_CYCLES(1), .PASSES(1), .ERR_W(4)) u_dut2 (
    .clk(clk), .rst(rst2), .start(start2), .c(c2), .a(a2), .b(b2), .busy(busy2),
    .done(done2), .pass(pass2), .mismatch(mis2), .err_count(err2), .vec_idx(vidx2));

  typedef struct packed {
    logic a, b, busy, done, pass, mis;
    logic [3:0] err;
    logic [1:0] vidx;
  } obs_t;

  typedef struct {
    int inst;
    int err;
    int pass;
    int mis;
    int first_mis;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  int   mis_cnt[3]   = '{0, 0, 0};
  int   first_mis[3] = '{-1, -1, -1};

  function automatic obs_t obs(input int i);
    obs_t o;
    case (i)
      0:       o = '{a0, b0, busy0, done0, pass0, mis0, err0, vidx0};
      1:       o = '{a1, b1, busy1, done1, pass1, mis1, {2'b00, err1}, vidx1};
      default: o = '{a2, b2, busy2, done2, pass2, mis2, err2, vidx2};
    endcase
    return o;
  endfunction

  function automatic logic get_rst(input int i);
    case (i)
      0:       return rst0;
      1:       return rst1;
      default: return rst2;
    endcase
  endfunction

  task automatic set_rst(input int i, input logic v);
    case (i)
      0:       rst0 = v;
      1:       rst1 = v;
      default: rst2 = v;
    endcase
  endtask

  task automatic set_start(input int i, input logic v);
    case (i)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic chk(input int i, input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %0d expected %0d (cycle %0d)", i, nm, act, exp, cyc);
    end
  endtask

  function automatic bit pending(input int i);
    foreach (sb[j]) if (sb[j].inst == i) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: tally mismatch pulses; on done, pop the oldest expectation of that instance.
  task automatic mon(input int i);
    obs_t o;
    exp_t x;
    int   k;
    o = obs(i);
    if (get_rst(i)) begin
      mis_cnt[i]   = 0;
      first_mis[i] = -1;
      return;
    end
    if (o.mis) begin
      if (first_mis[i] < 0) first_mis[i] = cyc;
      mis_cnt[i]++;
    end
    if (o.done) begin
      k = -1;
      foreach (sb[j]) if (k < 0 && sb[j].inst == i) k = j;
      if (k < 0) begin
        checks++;
        errors++;
        $display("FAIL inst%0d unexpected_done: got done=1 expected no run pending (cycle %0d)", i, cyc);
      end else begin
        x = sb[k];
        sb.delete(k);
        chk(i, "done_cycle", cyc, x.done_cyc);
        chk(i, "err_count", int'(o.err), x.err);
        chk(i, "pass", int'(o.pass), x.pass);
        chk(i, "busy_in_done", int'(o.busy), 0);
        chk(i, "mismatch_pulses", mis_cnt[i], x.mis);
        chk(i, "first_mismatch_cycle", first_mis[i], x.first_mis);
      end
      mis_cnt[i]   = 0;
      first_mis[i] = -1;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
    mon(2);
  end

  task automatic do_reset(input int i);
    @(negedge clk);
    set_rst(i, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk(i, "reset_state", int'(obs(i)), 0);
    set_rst(i, 1'b0);
    @(negedge clk);
    chk(i, "idle_after_reset", int'(obs(i)), 0);
  endtask

  // Pulse start for one edge and record what that run must produce.
  // fm_off: edges from the accept edge to the first mismatch pulse (-1 = none).
  task automatic start_run(input int i, input int s, input int p, input int err,
                           input int ps, input int mis, input int fm_off);
    exp_t x;
    @(negedge clk);
    set_start(i, 1'b1);
    x.inst      = i;
    x.err       = err;
    x.pass      = ps;
    x.mis       = mis;
    x.first_mis = (fm_off < 0) ? -1 : cyc + 1 + fm_off;
    x.done_cyc  = cyc + 1 + 4 * p * s;
    sb.push_back(x);
    @(negedge clk);
    set_start(i, 1'b0);
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while (pending(i) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (pending(i)) begin
      checks++;
      errors++;
      $display("FAIL inst%0d timeout: got no done within %0d cycles expected a done pulse", i, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

  initial begin
    do_reset(0);
    do_reset(1);
    do_reset(2);

    // Correct gate: vectors 00,01,10,11 each held two edges, clean pass.
    mode0 = 0;
    start_run(0, 2, 1, 0, 1, 0, -1);
    chk(0, "vec0_busy", int'(busy0), 1);
    for (int v = 0; v < 4; v++) begin
      if (v != 0) repeat (2) @(negedge clk);
      chk(0, "vec_idx", int'(vidx0), v);
      chk(0, "ab", int'({a0, b0}), v);
    end
    wait_done(0);
    repeat (3) @(negedge clk);
    chk(0, "pass_held", int'(pass0), 1);
    chk(0, "ab_back_to_00", int'({a0, b0, busy0}), 0);

    // Stuck-at-0: only vector 00 (expected 1) fails.
    mode0 = 1;
    start_run(0, 2, 1, 1, 0, 1, 2);
    wait_done(0);
    repeat (3) @(negedge clk);
    chk(0, "fail_pass_held", int'(pass0), 0);
    chk(0, "fail_err_held", int'(err0), 1);

    // Correct gate with start re-pulsed mid-run: no second run may appear.
    mode0 = 0;
    start_run(0, 2, 1, 0, 1, 0, -1);
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0);
    repeat (12) @(negedge clk);
    chk(0, "idle_after_ignored_start", int'(busy0), 0);

    // Reset on the fifth edge after accept aborts the run with no done pulse.
    start_run(0, 2, 1, 0, 1, 0, -1);
    repeat (4) @(negedge clk);
    rst0 = 1'b1;
    for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].inst == 0) sb.delete(j);
    @(negedge clk);
    chk(0, "abort_reset_state", int'(obs(0)), 0);
    rst0 = 1'b0;
    repeat (12) @(negedge clk);
    start_run(0, 2, 1, 0, 1, 0, -1);
    wait_done(0);

    // Stuck-at-1 over two passes: 6 misses, 2-bit counter saturates at 3.
    start_run(1, 2, 2, 3, 0, 6, 4);
    wait_done(1);
    repeat (3) @(negedge clk);
    chk(1, "sat_err_held", int'(err1), 3);

    // One-cycle-late gate at SETTLE_CYCLES=1; the delay flop is held clear through
    // the accept edge so vector 00 sees a stale 0: misses on 00 and 01 only.
    start_run(2, 1, 1, 2, 0, 2, 1);
    dly_clr = 1'b0;
    wait_done(2);
    repeat (4) @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
